// File: rtl/plic_claim_arbiter_if.sv
// Claim/complete bus between plic_regfile (master) and one per-target
// plic_claim_arbiter (slave). Carries the pending/enable/priority/threshold
// inputs, the claim/complete strobes and the arbiter's published results.
interface plic_claim_arbiter_if #(
  parameter int SOURCES       = 8,
  parameter int PRIORITY_BITS = 3,
  parameter int ID_BITS       = 4
);
  logic [SOURCES-1:0]               ip;
  logic [SOURCES:0]                 ie;
  logic [SOURCES*PRIORITY_BITS-1:0] p;
  logic [PRIORITY_BITS-1:0]         th;
  logic                             claim;
  logic                             complete;
  logic [ID_BITS-1:0]               complete_id;
  logic [ID_BITS-1:0]               id;
  logic                             irq;
  logic [ID_BITS-1:0]               claimed_id;
  logic                             claim_ack;
  logic [SOURCES-1:0]               gw_clear;
  logic                             complete_err;

  modport master (
    output ip, ie, p, th, claim, complete, complete_id,
    input  id, irq, claimed_id, claim_ack, gw_clear, complete_err
  );

  modport slave (
    input  ip, ie, p, th, claim, complete, complete_id,
    output id, irq, claimed_id, claim_ack, gw_clear, complete_err
  );
endinterface

// File: rtl/plic_claim_arbiter.sv
// Per-target PLIC arbiter. Scans one source per cycle, tracks the best
// eligible (pending, enabled, not in service, priority above threshold)
// source, publishes it after a full pass and runs the claim/complete
// handshake against an in-service mask.
// Optional feature: define PLIC_ARB_ERR_EN to build the invalid-complete
// detector driving complete_err; otherwise complete_err is tied low.
module plic_claim_arbiter #(
  parameter int SOURCES       = 8,
  parameter int PRIORITY_BITS = 3,
  parameter int ID_BITS       = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  plic_claim_arbiter_if.slave   arb_if
);

  localparam int NIDS = 2 ** ID_BITS;

  typedef enum logic {ST_SCAN, ST_PUBLISH} state_e;

  state_e                   state_q, state_d;
  logic [ID_BITS-1:0]       idx_q, idx_d;
  logic [ID_BITS-1:0]       best_id_q, best_id_d;
  logic [PRIORITY_BITS-1:0] best_p_q, best_p_d;
  logic [ID_BITS-1:0]       id_q, id_d;
  logic                     irq_q, irq_d;
  logic [ID_BITS-1:0]       claimed_id_q, claimed_id_d;
  logic                     claim_ack_q, claim_ack_d;
  logic [SOURCES-1:0]       gw_clear_q, gw_clear_d;
  // Indexed directly by ID; bit 0 and bits above SOURCES are never set.
  logic [NIDS-1:0]          in_service_q, in_service_d;

  logic [PRIORITY_BITS-1:0] prio [NIDS];
  logic [NIDS-1:0]          elig;
  logic                     complete_ok;
  logic                     restart;

  // Enable bit 0 belongs to the non-existent source 0.
  logic unused_ie0;
  assign unused_ie0 = arb_if.ie[0];

  // Unpack priorities by ID and evaluate per-source eligibility.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    elig = '0;
    for (int k = 0; k < NIDS; k++) prio[k] = '0;
    for (int k = 1; k <= SOURCES; k++) begin
      prio[k] = arb_if.p[(k-1)*PRIORITY_BITS +: PRIORITY_BITS];
      elig[k] = arb_if.ip[k-1] & arb_if.ie[k] & ~in_service_q[k] & (prio[k] > arb_if.th);
    end
  end

  assign complete_ok = arb_if.complete && (arb_if.complete_id != '0) &&
                       (arb_if.complete_id <= ID_BITS'(SOURCES)) &&
                       in_service_q[arb_if.complete_id];

  // Scan/publish FSM plus the claim/complete handshake, which overrides the scan.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    best_id_d    = best_id_q;
    best_p_d     = best_p_q;
    id_d         = id_q;
    irq_d        = irq_q;
    claimed_id_d = claimed_id_q;
    claim_ack_d  = 1'b0;
    gw_clear_d   = '0;
    in_service_d = in_service_q;
    restart      = 1'b0;

    case (state_q)
      ST_SCAN: begin
        // Strict compare: on a tie the lower ID, seen first, is kept.
        if (elig[idx_q] && (prio[idx_q] > best_p_q)) begin
          best_id_d = idx_q;
          best_p_d  = prio[idx_q];
        end
        if (idx_q == ID_BITS'(SOURCES)) state_d = ST_PUBLISH;
        else                            idx_d   = idx_q + 1'b1;
      end
      ST_PUBLISH: begin
        id_d      = best_id_q;
        irq_d     = (best_id_q != '0);
        best_id_d = '0;
        best_p_d  = '0;
        idx_d     = ID_BITS'(1);
        state_d   = ST_SCAN;
      end
      default: state_d = ST_SCAN;
    endcase

    // Complete is applied before claim so a same-ID pair leaves the source in service.
    if (complete_ok) begin
      in_service_d[arb_if.complete_id] = 1'b0;
      restart = 1'b1;
    end

    // Claim returns the currently published ID and drops any publish in flight.
    if (arb_if.claim) begin
      claimed_id_d = id_q;
      claim_ack_d  = 1'b1;
      id_d         = '0;
      irq_d        = 1'b0;
      if (id_q != '0) begin
        in_service_d[id_q] = 1'b1;
        gw_clear_d         = SOURCES'(1) << (id_q - 1'b1);
        restart            = 1'b1;
      end
    end

    if (restart) begin
      state_d   = ST_SCAN;
      idx_d     = ID_BITS'(1);
      best_id_d = '0;
      best_p_d  = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_SCAN;
      idx_q        <= ID_BITS'(1);
      best_id_q    <= '0;
      best_p_q     <= '0;
      id_q         <= '0;
      irq_q        <= 1'b0;
      claimed_id_q <= '0;
      claim_ack_q  <= 1'b0;
      gw_clear_q   <= '0;
      in_service_q <= '0;
    end else begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      idx_q        <= idx_d;
      best_id_q    <= best_id_d;
      best_p_q     <= best_p_d;
      id_q         <= id_d;
      irq_q        <= irq_d;
      claimed_id_q <= claimed_id_d;
      claim_ack_q  <= claim_ack_d;
      gw_clear_q   <= gw_clear_d;
      in_service_q <= in_service_d;
    end
  end

  assign arb_if.id         = id_q;
  assign arb_if.irq        = irq_q;
  assign arb_if.claimed_id = claimed_id_q;
  assign arb_if.claim_ack  = claim_ack_q;
  assign arb_if.gw_clear   = gw_clear_q;

`ifdef PLIC_ARB_ERR_EN
  logic complete_err_q;

  // Flag a complete naming ID 0, an ID beyond SOURCES, or a source not in service.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) complete_err_q <= 1'b0;
    else       complete_err_q <= arb_if.complete & ~complete_ok;
  end

  assign arb_if.complete_err = complete_err_q;
`else
  assign arb_if.complete_err = 1'b0;
`endif

endmodule

// File: tb/tb_plic_claim_arbiter.sv
// Directed bench for plic_claim_arbiter: reset, arbitration, ties, the
// claim/complete handshake, invalid completes and asynchronous reset.
module tb_plic_claim_arbiter;
  localparam int SOURCES = 8;
  localparam int PB      = 3;
  localparam int IDB     = 4;

`ifdef PLIC_ARB_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  int   n_checks = 0;
  int   n_bad    = 0;
  int   cyc;

  plic_claim_arbiter_if #(.SOURCES(SOURCES), .PRIORITY_BITS(PB), .ID_BITS(IDB)) bus ();

  plic_claim_arbiter #(.SOURCES(SOURCES), .PRIORITY_BITS(PB), .ID_BITS(IDB)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .arb_if (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_p(input int src, input logic [PB-1:0] v);
    bus.p[(src-1)*PB +: PB] = v;
  endtask

  task automatic src3_only();
    bus.ip = 8'h04;
    bus.ie = 9'h008;
    bus.p  = '0;
    set_p(3, 3'd5);
    bus.th = 3'd2;
  endtask

  task automatic pulse(input logic do_claim, input logic do_complete, input logic [IDB-1:0] cid);
    bus.claim       = do_claim;
    bus.complete    = do_complete;
    bus.complete_id = cid;
    tick(1);
    bus.claim       = 1'b0;
    bus.complete    = 1'b0;
    bus.complete_id = '0;
  endtask

  task automatic wait_id(input logic [IDB-1:0] exp, input int budget, output int cycles);
    cycles = 0;
    while ((bus.id !== exp) && (cycles < budget)) begin
      tick(1);
      cycles++;
    end
  endtask

  initial begin
    rstn            = 1'b0;
    bus.claim       = 1'b0;
    bus.complete    = 1'b0;
    bus.complete_id = '0;
    src3_only();
    #23;
    check("rst_id",         bus.id,           0);
    check("rst_irq",        bus.irq,          0);
    check("rst_claimed_id", bus.claimed_id,   0);
    check("rst_claim_ack",  bus.claim_ack,    0);
    check("rst_gw_clear",   bus.gw_clear,     0);
    check("rst_cmp_err",    bus.complete_err, 0);

    // 1: single eligible source, publish latency is SOURCES+1 cycles.
    @(posedge clk);
    #1;
    rstn = 1'b1;
    wait_id(4'd3, 12, cyc);
    check("t1_latency",   cyc,           9);
    check("t1_id",        bus.id,        3);
    check("t1_irq",       bus.irq,       1);
    check("t1_claim_ack", bus.claim_ack, 0);
    check("t1_gw_clear",  bus.gw_clear,  0);

    // 2: equal priorities pick the lower ID; a higher priority wins.
    bus.ip = 8'h12;
    bus.ie = 9'h024;
    bus.p  = '0;
    set_p(2, 3'd4);
    set_p(5, 3'd4);
    bus.th = 3'd0;
    tick(18);
    check("t2_tie_id",  bus.id,  2);
    check("t2_tie_irq", bus.irq, 1);
    set_p(5, 3'd6);
    tick(18);
    check("t2_hi_id",   bus.id,  5);

    // 3: claim masks the source until completed.
    src3_only();
    tick(18);
    check("t3_pre_id",     bus.id,         3);
    pulse(1'b1, 1'b0, '0);
    check("t3_claimed_id", bus.claimed_id, 3);
    check("t3_claim_ack",  bus.claim_ack,  1);
    check("t3_gw_clear",   bus.gw_clear,   8'h04);
    check("t3_irq",        bus.irq,        0);
    check("t3_id",         bus.id,         0);
    tick(1);
    check("t3_ack_drop",   bus.claim_ack,  0);
    check("t3_gw_drop",    bus.gw_clear,   0);
    tick(20);
    check("t3_masked_id",  bus.id,         0);
    pulse(1'b0, 1'b1, 4'd3);
    check("t3_cmp_err",    bus.complete_err, 0);
    tick(18);
    check("t3_post_id",    bus.id,         3);
    check("t3_post_irq",   bus.irq,        1);

    // 4: priority equal to threshold is not eligible; claim of ID 0.
    set_p(3, 3'd2);
    tick(18);
    check("t4_id",         bus.id,         0);
    check("t4_irq",        bus.irq,        0);
    pulse(1'b1, 1'b0, '0);
    check("t4_claimed_id", bus.claimed_id, 0);
    check("t4_claim_ack",  bus.claim_ack,  1);
    check("t4_gw_clear",   bus.gw_clear,   0);
    set_p(3, 3'd5);
    tick(18);
    check("t4_unmasked",   bus.id,         3);

    // 5: invalid completes are ignored and optionally flagged.
    pulse(1'b0, 1'b1, 4'd7);
    check("t5_err7",       bus.complete_err, ERR_EXP);
    tick(1);
    check("t5_err_drop",   bus.complete_err, 0);
    tick(18);
    check("t5_id7",        bus.id,           3);
    pulse(1'b0, 1'b1, 4'd0);
    check("t5_err0",       bus.complete_err, ERR_EXP);
    tick(18);
    check("t5_id0",        bus.id,           3);

    // 6: same-cycle claim and complete of ID 3 leaves 3 in service.
    pulse(1'b1, 1'b1, 4'd3);
    check("t6_claimed_id", bus.claimed_id,   3);
    check("t6_claim_ack",  bus.claim_ack,    1);
    check("t6_gw_clear",   bus.gw_clear,     8'h04);
    check("t6_cmp_err",    bus.complete_err, ERR_EXP);
    tick(20);
    check("t6_masked_id",  bus.id,           0);
    pulse(1'b0, 1'b1, 4'd3);
    tick(18);
    check("t6_post_id",    bus.id,           3);

    // Asynchronous reset mid-scan, then a full-latency rescan from idx 1.
    tick(4);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_id",         bus.id,         0);
    check("arst_irq",        bus.irq,        0);
    check("arst_claimed_id", bus.claimed_id, 0);
    tick(2);
    rstn = 1'b1;
    wait_id(4'd3, 12, cyc);
    check("arst_latency",    cyc,            9);
    check("arst_id_after",   bus.id,         3);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
